vga_sync_gen: RTL

VGA raster timing generator for the Pong display path. It sits directly downstream of the mod-n pixel-rate counter: that counter divides the system clock, and its terminal-count strobe arrives here as `pix_en`. On each strobe this block advances horizontal and vertical position counters and produces `hsync`, `vsync`, `video_on`, pixel coordinates and line/frame strobes. The ball, paddle and score renderers consume these outputs.

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_axis_timer.sv | 81 ++++++++
 rtl/vga_sync_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing constants and phase encoding for the VGA raster generator.
//   HActive..VBp : default 640x480@60 porch/sync lengths (pixels / lines)
//   HTotal/VTotal: derived line and frame totals
//   phase_e      : per-axis phase ACT -> FP -> SYNC -> BP -> ACT
//   next_phase() : successor phase in that cycle
package vga_timing_pkg;

  localparam int unsigned HActive = 640;
  localparam int unsigned HFp     = 16;
  localparam int unsigned HSync   = 96;
  localparam int unsigned HBp     = 48;
  localparam int unsigned VActive = 480;
  localparam int unsigned VFp     = 10;
  localparam int unsigned VSync   = 2;
  localparam int unsigned VBp     = 33;

  localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
  localparam int unsigned VTotal = VActive + VFp + VSync + VBp;

  typedef enum logic [1:0] {
    PhAct,
    PhFp,
    PhSync,
    PhBp
  } phase_e;

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    n = PhAct;
    case (p)
      PhAct:  n = PhFp;
      PhFp:   n = PhSync;
      PhSync: n = PhBp;
      PhBp:   n = PhAct;
      default: n = PhAct;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer: one raster axis (horizontal or vertical). Keeps the position counter and a
// phase FSM with its own in-phase counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   advance      : step the axis by one position
//   pos          : current position, 0..TOTAL-1 (registered)
//   phase        : phase the axis will occupy after this cycle's edge (next-state); the parent
//                  registers its decode so its outputs line up with pos
//   wrap         : pos is at TOTAL-1, i.e. the next advance wraps to 0
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         advance,
  output logic [W-1:0] pos,
  output phase_e       phase,
  output logic         wrap
);

  localparam int unsigned Total = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] PosLast  = W'(Total - 1);
  localparam logic [W-1:0] ActLast  = W'(ACTIVE - 1);
  localparam logic [W-1:0] FpLast   = W'(FP - 1);
  localparam logic [W-1:0] SyncLast = W'(SYNC - 1);
  localparam logic [W-1:0] BpLast   = W'(BP - 1);

  logic [W-1:0] pos_q, pos_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cnt_last;
  phase_e       phase_q, phase_d;

  assign wrap = (pos_q == PosLast);

  always_comb begin
    cnt_last = ActLast;
    case (phase_q)
      PhAct:   cnt_last = ActLast;
      PhFp:    cnt_last = FpLast;
      PhSync:  cnt_last = SyncLast;
      PhBp:    cnt_last = BpLast;
      default: cnt_last = ActLast;
    endcase
  end

  always_comb begin
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (advance) begin
      pos_d = wrap ? '0 : pos_q + 1'b1;
      if (cnt_q == cnt_last) begin
        cnt_d   = '0;
        phase_d = next_phase(phase_q);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q   <= '0;
      cnt_q   <= '0;
      phase_q <= PhAct;
    end else begin
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign pos   = pos_q;
  assign phase = phase_d;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator driven by an upstream pixel-rate strobe.
//   clk, reset_n : clock, asynchronous active-low reset
//   pix_en       : one-clk pixel strobe
//   x, y         : current raster position
//   hsync, vsync : active-low sync pulses
//   video_on     : inside the visible area
//   line_tick    : one-clk pulse after a horizontal wrap
//   frame_tick   : one-clk pulse after a frame wrap
//   frame_cnt    : 8-bit wrapping frame counter, present only with VGA_FRAME_CNT_EN defined
// All level and strobe outputs are registered from next-state decode so they change on the same
// edge as x/y.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActive,
  parameter int unsigned H_FP     = HFp,
  parameter int unsigned H_SYNC   = HSync,
  parameter int unsigned H_BP     = HBp,
  parameter int unsigned V_ACTIVE = VActive,
  parameter int unsigned V_FP     = VFp,
  parameter int unsigned V_SYNC   = VSync,
  parameter int unsigned V_BP     = VBp,
  parameter int unsigned W        = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pix_en,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic         line_tick,
  output logic         frame_tick
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]   frame_cnt
`endif
);

  logic   h_wrap, v_wrap, v_advance, frame_wrap;
  phase_e h_phase_d, v_phase_d;
  logic   hsync_q, vsync_q, video_on_q, line_tick_q, frame_tick_q;

  // The vertical axis steps only on the pixel that ends a line.
  assign v_advance  = pix_en & h_wrap;
  assign frame_wrap = v_advance & v_wrap;

  vga_axis_timer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (W)
  ) u_h_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (pix_en),
    .pos     (x),
    .phase   (h_phase_d),
    .wrap    (h_wrap)
  );

  vga_axis_timer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (W)
  ) u_v_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (v_advance),
    .pos     (y),
    .phase   (v_phase_d),
    .wrap    (v_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b1;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      hsync_q      <= (h_phase_d != PhSync);
      vsync_q      <= (v_phase_d != PhSync);
      video_on_q   <= (h_phase_d == PhAct) && (v_phase_d == PhAct);
      line_tick_q  <= v_advance;
      frame_tick_q <= frame_wrap;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
